main_memory_burst: RTL and testbench

MAIN_MEMORY_BURST -- requirements
Module: main_memory_burst

---
 rtl/mem_if_pkg.sv | 31 +++
 rtl/main_memory_burst_if.sv | 38 +++
 rtl/mem_line_array.sv | 54 +++++
 rtl/main_memory_burst.sv | 175 +++++++++++++++++
 tb/tb_main_memory_burst.sv | 276 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/mem_if_pkg.sv
// ---------------------------------------------------------------------------
// mem_if_pkg
// Constants and types shared between the main-memory burst model and the L2
// cache that talks to it: default bus geometry, the byte-offset width of a
// cache line, the burst FSM state encoding and the read/write polarity of the
// we_MEM request qualifier.
// ---------------------------------------------------------------------------
package mem_if_pkg;

    localparam int MEM_ADDR_WIDTH   = 32;   // byte-address width
    localparam int MEM_DATA_WIDTH   = 64;   // beat width
    localparam int MEM_BURST_LENGTH = 8;    // beats per 64-byte line
    localparam int LINE_OFFSET_W    = 6;    // byte offset inside a line

    // we_MEM polarity: high asks for a line read, low for a line write.
    localparam logic RW_READ  = 1'b1;
    localparam logic RW_WRITE = 1'b0;

    typedef enum logic [1:0] {
        IDLE        = 2'd0,
        LATENCY     = 2'd1,
        READ_BURST  = 2'd2,
        WRITE_BURST = 2'd3
    } mem_state_e;

    // Index width for a table of n entries, never narrower than one bit.
    function automatic int clog2_min1(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/main_memory_burst_if.sv
// ---------------------------------------------------------------------------
// main_memory_burst_if
// Request/handshake signals between a line initiator (master) and the main
// memory burst model (slave). The bidirectional beat bus is a plain inout
// port on the memory so that its tristate driver stays with the memory.
//   req       initiator -> memory  request valid
//   we_MEM    initiator -> memory  1 = read line, 0 = write line
//   addr_MEM  initiator -> memory  byte address
//   stb       memory -> initiator  beat strobe, each level change = one beat
//   busy      memory -> initiator  request accepted and burst in progress
// ---------------------------------------------------------------------------
interface main_memory_burst_if #(
    parameter int ADDR_WIDTH = mem_if_pkg::MEM_ADDR_WIDTH
) ();

    logic                  req;
    logic                  we_MEM;
    logic [ADDR_WIDTH-1:0] addr_MEM;
    logic                  stb;
    logic                  busy;

    modport master (
        output req,
        output we_MEM,
        output addr_MEM,
        input  stb,
        input  busy
    );

    modport slave (
        input  req,
        input  we_MEM,
        input  addr_MEM,
        output stb,
        output busy
    );

endinterface

// File: rtl/mem_line_array.sv
// ---------------------------------------------------------------------------
// mem_line_array
// Line storage for the main memory model: MEM_LINES lines of BURST_LENGTH
// beats. One synchronous write port and one combinational read port, both
// addressed by (line, beat). Every word powers up holding its own flat index
// (line*BURST_LENGTH + beat) so reads of never-written lines are predictable.
// Contents have no reset.
//   clk      clock, rising edge
//   wr_en    write strobe, wr_data lands in (wr_line, wr_beat) at the edge
//   rd_*     combinational read of (rd_line, rd_beat)
// ---------------------------------------------------------------------------
module mem_line_array #(
    parameter int DATA_WIDTH   = mem_if_pkg::MEM_DATA_WIDTH,
    parameter int BURST_LENGTH = mem_if_pkg::MEM_BURST_LENGTH,
    parameter int MEM_LINES    = 128,
    parameter int LINE_W       = 7,
    parameter int BEAT_W       = 3
) (
    input  logic                  clk,
    input  logic                  wr_en,
    input  logic [LINE_W-1:0]     wr_line,
    input  logic [BEAT_W-1:0]     wr_beat,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic [LINE_W-1:0]     rd_line,
    input  logic [BEAT_W-1:0]     rd_beat,
    output logic [DATA_WIDTH-1:0] rd_data
);

    localparam int WORDS = MEM_LINES * BURST_LENGTH;
    localparam int IDX_W = mem_if_pkg::clog2_min1(WORDS);

    logic [IDX_W-1:0]      wr_index;
    logic [IDX_W-1:0]      rd_index;
    logic [DATA_WIDTH-1:0] word_array [WORDS];

    assign wr_index = IDX_W'(32'(wr_line) * BURST_LENGTH + 32'(wr_beat));
    assign rd_index = IDX_W'(32'(rd_line) * BURST_LENGTH + 32'(rd_beat));

    // One register per word so each can carry its own power-on image value.
    for (genvar gi = 0; gi < WORDS; gi++) begin : g_word
        logic [DATA_WIDTH-1:0] word_q = DATA_WIDTH'(gi);

        always_ff @(posedge clk) begin
            if (wr_en && (wr_index == IDX_W'(gi))) begin
                word_q <= wr_data;
            end
        end

        assign word_array[gi] = word_q;
    end

    assign rd_data = word_array[rd_index];

endmodule

// File: rtl/main_memory_burst.sv
// ---------------------------------------------------------------------------
// main_memory_burst
// Behavioural main memory serving whole 64-byte lines as bursts of
// BURST_LENGTH beats over a shared bidirectional bus.
//   clk        clock, rising edge
//   rst_n      asynchronous active-low reset (storage keeps its contents)
//   bus        slave side of main_memory_burst_if (req/we_MEM/addr_MEM in,
//              stb/busy out)
//   data_MEM   bidirectional beat bus, driven only during a read burst
// A request accepted in IDLE waits ACCESS_LATENCY cycles, then each beat
// takes two cycles: phase A (setup) and phase B, at whose closing edge stb
// toggles and, for writes, the beat on data_MEM is stored.
// ---------------------------------------------------------------------------
module main_memory_burst #(
    parameter int ADDR_WIDTH     = mem_if_pkg::MEM_ADDR_WIDTH,
    parameter int DATA_WIDTH     = mem_if_pkg::MEM_DATA_WIDTH,
    parameter int BURST_LENGTH   = mem_if_pkg::MEM_BURST_LENGTH,
    parameter int MEM_LINES      = 128,
    parameter int ACCESS_LATENCY = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    main_memory_burst_if.slave    bus,
    inout  wire  [DATA_WIDTH-1:0] data_MEM
);

    import mem_if_pkg::*;

    localparam int LINE_W = clog2_min1(MEM_LINES);
    localparam int BEAT_W = clog2_min1(BURST_LENGTH);
    localparam int LAT_W  = 4;
    localparam int TAG_W  = ADDR_WIDTH - LINE_OFFSET_W;

    mem_state_e            state_q,   state_d;
    logic [LAT_W-1:0]      lat_cnt_q, lat_cnt_d;
    logic [BEAT_W-1:0]     beat_q,    beat_d;
    logic                  phase_q,   phase_d;     // 0 = phase A, 1 = phase B
    logic                  stb_q,     stb_d;
    logic                  busy_q,    busy_d;
    logic                  we_q,      we_d;
    logic [LINE_W-1:0]     line_q,    line_d;
    logic                  drive_q,   drive_d;
    logic [DATA_WIDTH-1:0] rd_data_q, rd_data_d;

    logic [LINE_W-1:0]     req_line;
    logic [BEAT_W-1:0]     arr_rd_beat;
    logic [DATA_WIDTH-1:0] arr_rd_data;
    logic                  arr_wr_en;
    logic                  unused_offset;

    // Line index: drop the byte offset, then fold onto the stored lines.
    assign req_line      = LINE_W'(bus.addr_MEM[ADDR_WIDTH-1:LINE_OFFSET_W] % TAG_W'(MEM_LINES));
    assign unused_offset = ^bus.addr_MEM[LINE_OFFSET_W-1:0];

    // The beat about to be presented: beat 0 when leaving LATENCY, otherwise
    // the one after the current beat (loaded at the close of phase B).
    assign arr_rd_beat = (state_q == LATENCY) ? '0 : beat_q + BEAT_W'(1);

    mem_line_array #(
        .DATA_WIDTH   (DATA_WIDTH),
        .BURST_LENGTH (BURST_LENGTH),
        .MEM_LINES    (MEM_LINES),
        .LINE_W       (LINE_W),
        .BEAT_W       (BEAT_W)
    ) u_array (
        .clk     (clk),
        .wr_en   (arr_wr_en),
        .wr_line (line_q),
        .wr_beat (beat_q),
        .wr_data (data_MEM),
        .rd_line (line_q),
        .rd_beat (arr_rd_beat),
        .rd_data (arr_rd_data)
    );

    always_comb begin
        state_d   = state_q;
        lat_cnt_d = lat_cnt_q;
        beat_d    = beat_q;
        phase_d   = phase_q;
        stb_d     = stb_q;
        busy_d    = busy_q;
        we_d      = we_q;
        line_d    = line_q;
        drive_d   = drive_q;
        rd_data_d = rd_data_q;
        arr_wr_en = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (bus.req) begin
                    line_d    = req_line;
                    we_d      = bus.we_MEM;
                    busy_d    = 1'b1;
                    lat_cnt_d = '0;
                    state_d   = LATENCY;
                end
            end

            LATENCY: begin
                if (lat_cnt_q == LAT_W'(ACCESS_LATENCY - 1)) begin
                    lat_cnt_d = '0;
                    beat_d    = '0;
                    phase_d   = 1'b0;
                    if (we_q == RW_READ) begin
                        state_d   = READ_BURST;
                        drive_d   = 1'b1;
                        rd_data_d = arr_rd_data;
                    end else begin
                        state_d   = WRITE_BURST;
                    end
                end else begin
                    lat_cnt_d = lat_cnt_q + LAT_W'(1);
                end
            end

            READ_BURST, WRITE_BURST: begin
                if (!phase_q) begin
                    phase_d = 1'b1;
                end else begin
                    // Close of phase B: the beat is handed over on this edge.
                    phase_d   = 1'b0;
                    stb_d     = ~stb_q;
                    arr_wr_en = (state_q == WRITE_BURST);
                    if (beat_q == BEAT_W'(BURST_LENGTH - 1)) begin
                        state_d = IDLE;
                        busy_d  = 1'b0;
                        drive_d = 1'b0;
                        beat_d  = '0;
                    end else begin
                        beat_d = beat_q + BEAT_W'(1);
                        if (state_q == READ_BURST) begin
                            rd_data_d = arr_rd_data;
                        end
                    end
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            lat_cnt_q <= '0;
            beat_q    <= '0;
            phase_q   <= 1'b0;
            stb_q     <= 1'b0;
            busy_q    <= 1'b0;
            we_q      <= RW_WRITE;
            line_q    <= '0;
            drive_q   <= 1'b0;
            rd_data_q <= '0;
        end else begin
            state_q   <= state_d;
            lat_cnt_q <= lat_cnt_d;
            beat_q    <= beat_d;
            phase_q   <= phase_d;
            stb_q     <= stb_d;
            busy_q    <= busy_d;
            we_q      <= we_d;
            line_q    <= line_d;
            drive_q   <= drive_d;
            rd_data_q <= rd_data_d;
        end
    end

    assign data_MEM = drive_q ? rd_data_q : 'z;
    assign bus.stb  = stb_q;
    assign bus.busy = busy_q;

endmodule

// File: tb/tb_main_memory_burst.sv
// ---------------------------------------------------------------------------
// tb_main_memory_burst
// Drives line reads and writes into main_memory_burst and compares beats,
// strobe timing, busy and bus ownership against a line-array model.
// The bench drives data_MEM itself whenever the memory must not, and checks
// that it reads back its own value, which shows the memory is not driving.
// ---------------------------------------------------------------------------
module tb_main_memory_burst;

    localparam int AW    = 32;
    localparam int DW    = 64;
    localparam int BL    = 8;
    localparam int LINES = 128;
    localparam int LAT   = 4;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    wire  [DW-1:0] data_bus;
    logic          tb_drive = 1'b1;
    logic [DW-1:0] tb_data  = '0;
    assign data_bus = tb_drive ? tb_data : 'z;

    main_memory_burst_if #(.ADDR_WIDTH(AW)) bus ();

    main_memory_burst #(
        .ADDR_WIDTH     (AW),
        .DATA_WIDTH     (DW),
        .BURST_LENGTH   (BL),
        .MEM_LINES      (LINES),
        .ACCESS_LATENCY (LAT)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .bus      (bus),
        .data_MEM (data_bus)
    );

    int n_cmp = 0;
    int n_bad = 0;

    logic [DW-1:0] model_mem [LINES][BL];
    logic [DW-1:0] wr_beats  [BL];
    logic [DW-1:0] obs_beat  [BL];
    int            obs_tcycle [BL];
    int            obs_toggles, obs_busy_fall, obs_bus_bad, obs_idle_stb;
    logic          obs_accept_busy;
    logic          obs_abort_stb, obs_abort_busy, obs_abort_bus_ok;

    // One request, then follow the burst edge by edge. Negedge n follows
    // accept edge + n. glitch_at raises req (with junk we/addr) for the edge
    // after negedge glitch_at; abort_after asserts reset once that many
    // strobe toggles have been seen.
    task automatic run_burst(input bit rd, input logic [AW-1:0] addr,
                             input int glitch_at, input int abort_after);
        logic          prev_stb;
        logic [DW-1:0] prev_data;
        bit            done;
        obs_toggles = 0; obs_busy_fall = -1; obs_bus_bad = 0; obs_idle_stb = 0;
        for (int k = 0; k < BL; k++) begin
            obs_beat[k] = '0;
            obs_tcycle[k] = -1;
        end
        bus.req = 1'b1; bus.we_MEM = rd; bus.addr_MEM = addr;
        tb_drive = 1'b1;
        tb_data = rd ? {$urandom, $urandom} : wr_beats[0];
        @(posedge clk);
        @(negedge clk);
        obs_accept_busy = bus.busy;
        bus.req = 1'b0; bus.we_MEM = 1'($urandom); bus.addr_MEM = $urandom;
        if (data_bus !== tb_data) obs_bus_bad++;
        prev_stb = bus.stb;
        prev_data = data_bus;
        done = 1'b0;
        for (int n = 1; n <= 64 && !done; n++) begin
            @(negedge clk);
            bus.req = (n == glitch_at);
            bus.we_MEM = 1'($urandom);
            bus.addr_MEM = $urandom;
            if (tb_drive && data_bus !== tb_data) obs_bus_bad++;
            if (bus.stb !== prev_stb) begin
                if (obs_toggles < BL) begin
                    obs_tcycle[obs_toggles] = n;
                    obs_beat[obs_toggles] = prev_data;
                end
                obs_toggles++;
                if (!rd && obs_toggles < BL) tb_data = wr_beats[obs_toggles];
            end
            prev_stb = bus.stb;
            prev_data = data_bus;
            if (rd && n == LAT - 1) tb_drive = 1'b0;
            if (abort_after > 0 && obs_toggles == abort_after) begin
                rst_n = 1'b0;
                #1;
                obs_abort_stb = bus.stb;
                obs_abort_busy = bus.busy;
                tb_drive = 1'b1;
                tb_data = {$urandom, $urandom};
                #1;
                obs_abort_bus_ok = (data_bus === tb_data);
                bus.req = 1'b0;
                @(negedge clk);
                rst_n = 1'b1;
                done = 1'b1;
            end else if (bus.busy === 1'b0) begin
                obs_busy_fall = n;
                bus.req = 1'b0;
                if (bus.stb !== 1'b0) obs_idle_stb++;
                tb_drive = 1'b1;
                tb_data = {$urandom, $urandom};
                @(negedge clk);
                if (data_bus !== tb_data) obs_bus_bad++;
                if (bus.stb !== 1'b0) obs_idle_stb++;
                done = 1'b1;
            end
        end
        bus.req = 1'b0;
        tb_drive = 1'b1;
        $display("burst %s addr=%h line=%0d toggles=%0d busy_fall=%0d",
                 rd ? "read " : "write", addr, (addr >> 6) % LINES, obs_toggles, obs_busy_fall);
    endtask

    task automatic test_reset();
        bus.req = 1'b0; bus.we_MEM = 1'b0; bus.addr_MEM = '0;
        tb_drive = 1'b1; tb_data = {$urandom, $urandom};
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if (bus.busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy: got %b want 0", bus.busy); end
        n_cmp++;
        if (bus.stb !== 1'b0) begin n_bad++; $display("FAIL reset_stb: got %b want 0", bus.stb); end
        n_cmp++;
        if (data_bus !== tb_data) begin n_bad++; $display("FAIL reset_bus_z: got %h want %h", data_bus, tb_data); end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_first_read();
        run_burst(1'b1, 32'h0000_0040, -1, -1);
        n_cmp++;
        if (obs_accept_busy !== 1'b1) begin n_bad++; $display("FAIL first_read_busy_rise: got %b want 1", obs_accept_busy); end
        for (int k = 0; k < BL; k++) begin
            n_cmp++;
            if (obs_beat[k] !== DW'(8 + k)) begin
                n_bad++; $display("FAIL first_read_beat%0d: got %h want %h", k, obs_beat[k], DW'(8 + k));
            end
            n_cmp++;
            if (obs_tcycle[k] != LAT + 2 + 2 * k) begin
                n_bad++; $display("FAIL first_read_toggle%0d_cycle: got %0d want %0d", k, obs_tcycle[k], LAT + 2 + 2 * k);
            end
        end
        n_cmp++;
        if (obs_toggles != BL) begin n_bad++; $display("FAIL first_read_toggles: got %0d want %0d", obs_toggles, BL); end
        n_cmp++;
        if (obs_busy_fall != LAT + 2 * BL) begin n_bad++; $display("FAIL first_read_busy_fall: got %0d want %0d", obs_busy_fall, LAT + 2 * BL); end
        n_cmp++;
        if (obs_bus_bad != 0) begin n_bad++; $display("FAIL first_read_bus_z: got %0d driven cycles want 0", obs_bus_bad); end
        n_cmp++;
        if (obs_idle_stb != 0) begin n_bad++; $display("FAIL first_read_idle_stb: got %0d high cycles want 0", obs_idle_stb); end
    endtask

    task automatic test_write_then_read();
        for (int k = 0; k < BL; k++) wr_beats[k] = DW'(8'hA0 + k);
        run_burst(1'b0, 32'h0000_0080, -1, -1);
        for (int k = 0; k < BL; k++) model_mem[2][k] = wr_beats[k];
        n_cmp++;
        if (obs_busy_fall != LAT + 2 * BL) begin n_bad++; $display("FAIL write_busy_fall: got %0d want %0d", obs_busy_fall, LAT + 2 * BL); end
        n_cmp++;
        if (obs_bus_bad != 0) begin n_bad++; $display("FAIL write_bus_z: got %0d driven cycles want 0", obs_bus_bad); end
        run_burst(1'b1, 32'h0000_0085, -1, -1);
        for (int k = 0; k < BL; k++) begin
            n_cmp++;
            if (obs_beat[k] !== DW'(8'hA0 + k)) begin
                n_bad++; $display("FAIL raw_beat%0d: got %h want %h", k, obs_beat[k], DW'(8'hA0 + k));
            end
        end
    endtask

    task automatic test_ignore_req();
        run_burst(1'b1, 32'h0000_0000, 4, -1);
        for (int k = 0; k < BL; k++) begin
            n_cmp++;
            if (obs_beat[k] !== DW'(k)) begin
                n_bad++; $display("FAIL ignore_req_beat%0d: got %h want %h", k, obs_beat[k], DW'(k));
            end
        end
        n_cmp++;
        if (obs_busy_fall != LAT + 2 * BL) begin n_bad++; $display("FAIL ignore_req_busy_fall: got %0d want %0d", obs_busy_fall, LAT + 2 * BL); end
        // A req pulse taken as a new request would keep busy high afterwards.
        repeat (3) @(negedge clk);
        n_cmp++;
        if (bus.busy !== 1'b0) begin n_bad++; $display("FAIL ignore_req_idle_busy: got %b want 0", bus.busy); end
    endtask

    task automatic test_reset_abort();
        logic [DW-1:0] exp_v;
        for (int k = 0; k < BL; k++) wr_beats[k] = DW'(8'hB0 + k);
        run_burst(1'b0, 32'h0000_00C0, -1, 4);
        for (int k = 0; k < 4; k++) model_mem[3][k] = wr_beats[k];
        n_cmp++;
        if (obs_abort_stb !== 1'b0) begin n_bad++; $display("FAIL abort_stb: got %b want 0", obs_abort_stb); end
        n_cmp++;
        if (obs_abort_busy !== 1'b0) begin n_bad++; $display("FAIL abort_busy: got %b want 0", obs_abort_busy); end
        n_cmp++;
        if (obs_abort_bus_ok !== 1'b1) begin n_bad++; $display("FAIL abort_bus_z: got driven want released"); end
        @(negedge clk);
        run_burst(1'b1, 32'h0000_00C0, -1, -1);
        for (int k = 0; k < BL; k++) begin
            exp_v = (k < 4) ? DW'(8'hB0 + k) : DW'(3 * BL + k);
            n_cmp++;
            if (obs_beat[k] !== exp_v) begin
                n_bad++; $display("FAIL abort_read_beat%0d: got %h want %h", k, obs_beat[k], exp_v);
            end
        end
    endtask

    // Random reads/writes over a few lines, with aliasing above the line
    // range and stray req pulses during the burst.
    task automatic test_random();
        bit            rd;
        logic [AW-1:0] addr;
        int            line, glitch;
        for (int t = 0; t < 24; t++) begin
            rd     = 1'($urandom_range(0, 1));
            addr   = AW'($urandom_range(0, 3) * 64 + $urandom_range(0, 63)
                       + $urandom_range(0, 1) * (LINES * 64));
            line   = int'((addr >> 6) % LINES);
            glitch = ($urandom_range(0, 1) == 1) ? int'($urandom_range(1, 18)) : -1;
            if (!rd) for (int k = 0; k < BL; k++) wr_beats[k] = {$urandom, $urandom};
            run_burst(rd, addr, glitch, -1);
            if (rd) begin
                for (int k = 0; k < BL; k++) begin
                    n_cmp++;
                    if (obs_beat[k] !== model_mem[line][k]) begin
                        n_bad++; $display("FAIL rand%0d_beat%0d line %0d: got %h want %h", t, k, line, obs_beat[k], model_mem[line][k]);
                    end
                end
            end else begin
                for (int k = 0; k < BL; k++) model_mem[line][k] = wr_beats[k];
            end
            n_cmp++;
            if (obs_busy_fall != LAT + 2 * BL) begin n_bad++; $display("FAIL rand%0d_busy_fall: got %0d want %0d", t, obs_busy_fall, LAT + 2 * BL); end
            n_cmp++;
            if (obs_bus_bad != 0 || obs_idle_stb != 0) begin
                n_bad++; $display("FAIL rand%0d_bus_idle: got %0d driven / %0d stb-high want 0/0", t, obs_bus_bad, obs_idle_stb);
            end
        end
    endtask

    initial begin
        for (int l = 0; l < LINES; l++)
            for (int k = 0; k < BL; k++)
                model_mem[l][k] = DW'(l * BL + k);
        bus.req = 1'b0; bus.we_MEM = 1'b0; bus.addr_MEM = '0;
        test_reset();
        test_first_read();
        test_write_then_read();
        test_ignore_req();
        test_reset_abort();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got no finish within time limit want finish");
        $fatal(1, "time limit");
    end

endmodule
